// File: rtl/mc_controller_v2.sv
// Multicycle RV32I control unit: opcode decode, Moore sequencing FSM, mux selects and write strobes.
// Optional memory-wait timeout trap enabled by defining CTRL_TIMEOUT_EN.
//   state    | meaning
//   FETCH    | read instruction, PC += 4
//   DECODE   | precompute OldPC + Imm, dispatch on opcode
//   MEMADR   | A + Imm address
//   MEMREAD  | load access, wait for MemReady
//   MEMWB    | write load data to rd
//   MEMWRITE | store access, wait for MemReady
//   EXECR    | register-register ALU op
//   EXECI    | register-immediate ALU op
//   ALUWB    | write ALUOut to rd
//   BRANCH   | compare, conditional PC write
//   JAL      | PC <= target, ALU forms link
//   JALR1    | PC <= A + Imm
//   JALR2    | ALU forms link
//   LUI      | 0 + Imm
//   AUIPC    | OldPC + Imm
//   TRAP     | sticky illegal/timeout, absorbing until reset
module mc_controller_v2 #(
    parameter int ALUC_W         = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              LtS,
    input  logic              LtU,
    input  logic              MemReady,
    output logic [2:0]        ImmSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic              AdrSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              MemReq,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              Trap
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
        S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd2;
    localparam logic [3:0] A_OR   = 4'd3;
    localparam logic [3:0] A_XOR  = 4'd4;
    localparam logic [3:0] A_SLT  = 4'd5;
    localparam logic [3:0] A_SLTU = 4'd6;
    localparam logic [3:0] A_SLL  = 4'd7;
    localparam logic [3:0] A_SRL  = 4'd8;
    localparam logic [3:0] A_SRA  = 4'd9;

    state_t     state, state_next;
    logic [3:0] alu;
    logic       mem_req, ir_w, pc_w, reg_w, mem_w;
    logic       timeout;

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? A_SUB : A_ADD;
            3'b001:  alu_dec = A_SLL;
            3'b010:  alu_dec = A_SLT;
            3'b011:  alu_dec = A_SLTU;
            3'b100:  alu_dec = A_XOR;
            3'b101:  alu_dec = alt ? A_SRA : A_SRL;
            3'b110:  alu_dec = A_OR;
            default: alu_dec = A_AND;
        endcase
    endfunction

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BR:                  ImmSrc = 3'b010;
            OP_JAL:                 ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout = waiting && !MemReady && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Any state change clears the count, so each wait state starts from zero on entry.
    always_ff @(posedge clk) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state_next != state)
            wait_cnt <= '0;
        else if (waiting && !MemReady)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    localparam bit TIMEOUT_OFF = (TIMEOUT_CYCLES >= 0);
    assign timeout = !TIMEOUT_OFF;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        alu        = A_ADD;
        mem_req    = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (timeout) begin
                    state_next = S_TRAP;
                end else if (MemReady) begin
                    ir_w       = 1'b1;
                    pc_w       = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BR:             state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR1;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (timeout)
                    state_next = S_TRAP;
                else if (MemReady)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_w   = !timeout;
                AdrSrc  = 1'b1;
                if (timeout)
                    state_next = S_TRAP;
                else if (MemReady)
                    state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu        = alu_dec(funct3, funct7b5);
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu        = alu_dec(funct3, funct7b5 && (funct3 == 3'b101));
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                alu        = A_SUB;
                state_next = S_FETCH;
                case (funct3)
                    3'b000:  pc_w = Zero;
                    3'b001:  pc_w = !Zero;
                    3'b100:  pc_w = LtS;
                    3'b101:  pc_w = !LtS;
                    3'b110:  pc_w = LtU;
                    3'b111:  pc_w = !LtU;
                    default: state_next = S_TRAP;
                endcase
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_w       = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_w       = 1'b1;
                state_next = S_JALR2;
            end
            S_JALR2: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                state_next = S_ALUWB;
            end
            default: state_next = S_TRAP;
        endcase
    end

    assign ALUControl = ALUC_W'(alu);

    // Reset is applied combinationally too, so nothing fires while it is held low.
    assign MemReq   = mem_req & reset;
    assign IRWrite  = ir_w    & reset;
    assign PCWrite  = pc_w    & reset;
    assign RegWrite = reg_w   & reset;
    assign MemWrite = mem_w   & reset;
    assign Trap     = (state == S_TRAP) & reset;

endmodule

// File: tb/tb_mc_controller_v2.sv
// Scoreboard bench for mc_controller_v2: directed instruction sequences push per-cycle expectations,
// a negedge monitor pops and compares. Timeout sequence runs only with CTRL_TIMEOUT_EN.
module tb_mc_controller_v2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0, LtS = 1'b0, LtU = 1'b0;
    logic       MemReady = 1'b1;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc;
    logic [3:0] ALUControl;
    logic       MemReq, IRWrite, PCWrite, RegWrite, MemWrite, Trap;

    mc_controller_v2 #(.ALUC_W(4), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LtS(LtS), .LtU(LtU), .MemReady(MemReady),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .ALUControl(ALUControl), .MemReq(MemReq), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Trap(Trap)
    );

    always #5 clk = ~clk;

    // strobe vector order: {MemReq, IRWrite, PCWrite, RegWrite, MemWrite, Trap}
    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_F1   = 6'b111000;
    localparam logic [5:0] ST_REQ  = 6'b100000;
    localparam logic [5:0] ST_PCW  = 6'b001000;
    localparam logic [5:0] ST_RW   = 6'b000100;
    localparam logic [5:0] ST_MW   = 6'b100010;
    localparam logic [5:0] ST_TRAP = 6'b000001;
    localparam logic [5:0] C_ALU = 6'b000001, C_RS = 6'b000010, C_SA = 6'b000100,
                           C_SB  = 6'b001000, C_ADR = 6'b010000, C_IMM = 6'b100000;

    typedef struct {
        string      name;
        logic [5:0] strb;
        logic [5:0] care;
        logic [3:0] alu;
        logic [1:0] rs, sa, sb;
        logic       adr;
        logic [2:0] imm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    always @(negedge clk) begin
        logic [5:0] got;
        exp_t e;
        logic bad;
        got = {MemReq, IRWrite, PCWrite, RegWrite, MemWrite, Trap};
        if (q.size() > 0) begin
            e = q.pop_front();
            bad = (got !== e.strb)
               || (e.care[0] && ALUControl !== e.alu)
               || (e.care[1] && ResultSrc  !== e.rs)
               || (e.care[2] && ALUSrcA    !== e.sa)
               || (e.care[3] && ALUSrcB    !== e.sb)
               || (e.care[4] && AdrSrc     !== e.adr)
               || (e.care[5] && ImmSrc     !== e.imm);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s @%0t: got strb=%b alu=%0d rs=%b sa=%b sb=%b adr=%b imm=%b ; expected strb=%b alu=%0d rs=%b sa=%b sb=%b adr=%b imm=%b care=%b",
                         e.name, $time, got, ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ImmSrc,
                         e.strb, e.alu, e.rs, e.sa, e.sb, e.adr, e.imm, e.care);
            end
        end else if (got !== ST_NONE) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output @%0t: got strb=%b expected %b", $time, got, ST_NONE);
        end
    end

    task automatic step(input string nm, input logic rn, input logic mr, input logic [5:0] strb,
                        input logic [5:0] care, input logic [3:0] alu, input logic [1:0] rs,
                        input logic [1:0] sa, input logic [1:0] sb, input logic adr, input logic [2:0] imm);
        exp_t e;
        reset = rn;
        MemReady = mr;
        e.name = nm; e.strb = strb; e.care = care; e.alu = alu;
        e.rs = rs; e.sa = sa; e.sb = sb; e.adr = adr; e.imm = imm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic t_rst();            step("reset", 1'b0, 1'b1, ST_NONE, 6'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0); endtask
    task automatic t_fetch(input logic mr);
        step("fetch", 1'b1, mr, mr ? ST_F1 : ST_REQ, C_ALU|C_RS|C_SA|C_SB|C_ADR, 4'd0, 2'b10, 2'b00, 2'b10, 1'b0, 3'd0);
    endtask
    task automatic t_decode(input logic [2:0] imm);
        step("decode", 1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB|C_IMM, 4'd0, 2'd0, 2'b01, 2'b01, 1'b0, imm);
    endtask
    task automatic t_execr(input logic [3:0] alu); step("execr", 1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB, alu, 2'd0, 2'b10, 2'b00, 1'b0, 3'd0); endtask
    task automatic t_execi(input logic [3:0] alu); step("execi", 1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB, alu, 2'd0, 2'b10, 2'b01, 1'b0, 3'd0); endtask
    task automatic t_aluwb();          step("aluwb", 1'b1, 1'b1, ST_RW, C_RS, 4'd0, 2'b00, 2'd0, 2'd0, 1'b0, 3'd0); endtask
    task automatic t_memadr();         step("memadr", 1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB, 4'd0, 2'd0, 2'b10, 2'b01, 1'b0, 3'd0); endtask
    task automatic t_memread(input logic mr); step("memread", 1'b1, mr, ST_REQ, C_RS|C_ADR, 4'd0, 2'b00, 2'd0, 2'd0, 1'b1, 3'd0); endtask
    task automatic t_memwb();          step("memwb", 1'b1, 1'b1, ST_RW, C_RS, 4'd0, 2'b01, 2'd0, 2'd0, 1'b0, 3'd0); endtask
    task automatic t_memwrite(input logic mr); step("memwrite", 1'b1, mr, ST_MW, C_RS|C_ADR, 4'd0, 2'b00, 2'd0, 2'd0, 1'b1, 3'd0); endtask
    task automatic t_branch(input logic tk);
        step("branch", 1'b1, 1'b1, tk ? ST_PCW : ST_NONE, C_ALU|C_RS|C_SA|C_SB, 4'd1, 2'b00, 2'b10, 2'b00, 1'b0, 3'd0);
    endtask
    task automatic t_jal();   step("jal",   1'b1, 1'b1, ST_PCW, C_ALU|C_RS|C_SA|C_SB, 4'd0, 2'b00, 2'b01, 2'b10, 1'b0, 3'd0); endtask
    task automatic t_jalr1(); step("jalr1", 1'b1, 1'b1, ST_PCW, C_ALU|C_RS|C_SA|C_SB, 4'd0, 2'b10, 2'b10, 2'b01, 1'b0, 3'd0); endtask
    task automatic t_jalr2(); step("jalr2", 1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB, 4'd0, 2'd0, 2'b01, 2'b10, 1'b0, 3'd0); endtask
    task automatic t_lui();   step("lui",   1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB, 4'd0, 2'd0, 2'b11, 2'b01, 1'b0, 3'd0); endtask
    task automatic t_auipc(); step("auipc", 1'b1, 1'b1, ST_NONE, C_ALU|C_SA|C_SB, 4'd0, 2'd0, 2'b01, 2'b01, 1'b0, 3'd0); endtask
    task automatic t_trap();  step("trap",  1'b1, 1'b1, ST_TRAP, 6'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0); endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    initial begin
        @(posedge clk);
        #1;
        t_rst(); t_rst();

        set_instr(7'b0110011, 3'b000, 1'b0);                 // add
        t_fetch(1); t_decode(3'b000); t_execr(4'd0); t_aluwb();
        set_instr(7'b0110011, 3'b000, 1'b1);                 // sub
        t_fetch(1); t_decode(3'b000); t_execr(4'd1); t_aluwb();
        set_instr(7'b0110011, 3'b101, 1'b1);                 // sra
        t_fetch(1); t_decode(3'b000); t_execr(4'd9); t_aluwb();

        set_instr(7'b0010011, 3'b000, 1'b1);                 // addi: bit30 ignored
        t_fetch(1); t_decode(3'b000); t_execi(4'd0); t_aluwb();
        set_instr(7'b0010011, 3'b101, 1'b1);                 // srai
        t_fetch(1); t_decode(3'b000); t_execi(4'd9); t_aluwb();
        set_instr(7'b0010011, 3'b011, 1'b0);                 // sltiu
        t_fetch(1); t_decode(3'b000); t_execi(4'd6); t_aluwb();

        set_instr(7'b0000011, 3'b010, 1'b0);                 // lw, 3 wait cycles
        t_fetch(1); t_decode(3'b000); t_memadr();
        t_memread(0); t_memread(0); t_memread(0); t_memread(1); t_memwb();

        set_instr(7'b0100011, 3'b010, 1'b0);                 // sw, 1 wait cycle
        t_fetch(1); t_decode(3'b001); t_memadr(); t_memwrite(0); t_memwrite(1);

        set_instr(7'b0000011, 3'b010, 1'b0);                 // fetch wait then lw
        t_fetch(0); t_fetch(0); t_fetch(1); t_decode(3'b000); t_memadr(); t_memread(1); t_memwb();

        LtS = 1'b1; LtU = 1'b0; Zero = 1'b0;
        set_instr(7'b1100011, 3'b101, 1'b0);                 // bge, LtS=1: not taken
        t_fetch(1); t_decode(3'b010); t_branch(0);
        LtS = 1'b0; LtU = 1'b1;
        set_instr(7'b1100011, 3'b110, 1'b0);                 // bltu, LtU=1: taken
        t_fetch(1); t_decode(3'b010); t_branch(1);
        Zero = 1'b1;
        set_instr(7'b1100011, 3'b001, 1'b0);                 // bne, Zero=1: not taken
        t_fetch(1); t_decode(3'b010); t_branch(0);
        set_instr(7'b1100011, 3'b000, 1'b0);                 // beq, Zero=1: taken
        t_fetch(1); t_decode(3'b010); t_branch(1);
        Zero = 1'b0; LtU = 1'b0;

        set_instr(7'b1101111, 3'b000, 1'b0);                 // jal
        t_fetch(1); t_decode(3'b011); t_jal(); t_aluwb();
        set_instr(7'b0110111, 3'b000, 1'b0);                 // lui
        t_fetch(1); t_decode(3'b100); t_lui(); t_aluwb();
        set_instr(7'b0010111, 3'b000, 1'b0);                 // auipc
        t_fetch(1); t_decode(3'b100); t_auipc(); t_aluwb();
        set_instr(7'b1100111, 3'b000, 1'b0);                 // jalr
        t_fetch(1); t_decode(3'b000); t_jalr1(); t_jalr2(); t_aluwb();

        t_fetch(1); t_decode(3'b000); t_jalr1();             // jalr, reset during JALR2
        step("jalr2_reset", 1'b0, 1'b1, ST_NONE, 6'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
        set_instr(7'b0110011, 3'b000, 1'b0);
        t_fetch(1); t_decode(3'b000); t_execr(4'd0); t_aluwb();

        set_instr(7'b1111111, 3'b000, 1'b0);                 // illegal opcode
        t_fetch(1); t_decode(3'b000); t_trap(); t_trap(); t_trap();
        set_instr(7'b0110011, 3'b000, 1'b0);
        t_trap();                                            // stays trapped with a legal op
        t_rst();
        t_fetch(1); t_decode(3'b000); t_execr(4'd0); t_aluwb();

        set_instr(7'b1100011, 3'b010, 1'b0);                 // illegal branch funct3
        LtS = 1'b1; LtU = 1'b1;
        t_fetch(1); t_decode(3'b010); t_branch(0); t_trap(); t_trap();
        LtS = 1'b0; LtU = 1'b0;
        t_rst();

`ifdef CTRL_TIMEOUT_EN
        set_instr(7'b0110011, 3'b000, 1'b0);
        for (int i = 0; i < 16; i++) t_fetch(0);
        t_trap(); t_trap();
        t_rst();
        set_instr(7'b0000011, 3'b010, 1'b0);                 // load timeout in MEMREAD
        t_fetch(1); t_decode(3'b000); t_memadr();
        for (int i = 0; i < 16; i++) t_memread(0);
        t_trap();
        t_rst();
`endif

        reset = 1'b0;
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
- Second-generation control unit for the multicycle RV32I core.
- Decodes opcode/funct fields, sequences the datapath through a Moore FSM and drives all mux selects and write strobes.
- Adds over the previous controller:
  - full branch set
  - JAL, JALR, LUI, AUIPC
  - a wider ALU control field
  - a MemReady wait handshake on every memory state
  - a sticky trap on illegal encodings
- Sits between the instruction register fields and the datapath.

Parameters:
ALUC_W, 4, width of ALUControl; must be >= 4
TIMEOUT_CYCLES, 15, max wait cycles in one memory state before trap (used only with CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
op  in  7  instruction opcode
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero  in  1  ALU result == 0
LtS  in  1  signed A < B
LtU  in  1  unsigned A < B
MemReady  in  1  memory completes the current access this cycle
ImmSrc  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
ALUSrcA  out  2  00 PC, 01 OldPC, 10 A, 11 zero
ALUSrcB  out  2  00 B, 01 ImmExt, 10 const 4
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
AdrSrc  out  1  0 PC, 1 Result
ALUControl  out  ALUC_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra (zero-extended)
MemReq  out  1  memory access request
IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath write strobes
Trap  out  1  sticky illegal-instruction / timeout flag

Behaviour:
- Reset: reset==0 at a rising edge puts the FSM in FETCH, clears Trap and clears the wait counter. While reset==0, all strobes, MemReq and Trap are forced to 0. A reset mid-instruction abandons the instruction and performs no writes.
- ImmSrc is decoded combinationally from op in every state. Illegal op drives 000.
- States (Moore outputs; unlisted selects are don't-care, unlisted strobes are 0):
  - FETCH: MemReq=1, AdrSrc=0, A=PC, B=4, add, ResultSrc=10. When MemReady=1: IRWrite=1, PCWrite=1, next DECODE. Otherwise stay.
  - DECODE: A=OldPC, B=Imm, add (precomputes branch/JAL target). Next by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - else -> TRAP
  - MEMADR: A=A, B=Imm, add. Next MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Holds until MemReady, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Holds until MemReady, then FETCH.
  - EXECR: A=A, B=B. ALUControl from funct3/funct7b5; sub when funct3=000 and funct7b5=1. Next ALUWB.
  - EXECI: A=A, B=Imm. funct7b5 is honoured only for funct3=101 (srai). Next ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: A=A, B=B, sub, ResultSrc=00. PCWrite=taken, where taken is:
    - beq: Zero
    - bne: !Zero
    - blt: LtS
    - bge: !LtS
    - bltu: LtU
    - bgeu: !LtU
    - funct3 010/011 -> TRAP with no PCWrite.
    - Otherwise next FETCH.
  - JAL: A=OldPC, B=4, add, ResultSrc=00, PCWrite=1 -> ALUWB.
  - JALR1: A=A, B=Imm, add, ResultSrc=10, PCWrite=1 -> JALR2.
  - JALR2: A=OldPC, B=4, add -> ALUWB.
  - LUI: A=zero, B=Imm, add -> ALUWB.
  - AUIPC: A=OldPC, B=Imm, add -> ALUWB.
  - TRAP: Trap=1, all strobes 0, MemReq=0. Absorbing until reset.
- Latency with MemReady tied 1:
  - R/I/LUI/AUIPC: 4 cycles
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
- Each wait cycle adds 1.
- If MemReady rises in the same cycle the state is entered, the access completes that cycle.

Optional Feature:
- CTRL_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH, MEMREAD or MEMWRITE and increments on each cycle with MemReady=0.
  - When the counter reaches TIMEOUT_CYCLES and MemReady is still 0, next state is TRAP and no strobe fires.
- CTRL_TIMEOUT_EN undefined: no counter; waits are unbounded.

Test Plan:
- reset=0 for 2 cycles with MemReady=1 -> all strobes 0, Trap=0. After release, first cycle is FETCH: MemReq=1, IRWrite=1, PCWrite=1.
- add, then sub (op=0110011, funct3=000, funct7b5=0/1), MemReady=1 -> EXECR ALUControl=0 then 1. RegWrite pulses exactly once, 4 cycles after fetch.
- lw with MemReady low for 3 cycles in MEMREAD -> MemReq held 4 cycles, RegWrite one cycle after MemReady, ResultSrc=01. Total 8 cycles.
- bge with LtS=1 -> no PCWrite in BRANCH. bltu with LtU=1 -> PCWrite=1, ResultSrc=00.
- op=1111111, or branch funct3=010 -> Trap=1 sticky, no writes, cleared only by reset=0.
- CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=15, MemReady stuck 0 in FETCH -> Trap after 16 cycles in FETCH, IRWrite never asserted. Reset mid-JALR2 -> FETCH, no RegWrite.
